// File: rtl/dbus_ram.sv
// dbus_ram: single-port word RAM that responds on the dcpu memory bus.
//
// Decodes a 2^AW-word address window at BASE, inserts WAIT_STATES extra
// cycles after accepting a request, then performs the access and pulses
// o_ack for one cycle. o_dat is zero whenever o_ack is low, so several
// responders may be OR-ed onto one initiator.
//
// Optional feature (macro DBUS_RAM_ROPROT_EN): writes to the lowest
// RO_WORDS words of the window are discarded but still acknowledged.
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_cs       request, held high by the initiator until ack
//   i_we       1 = write, 0 = read (qualified by i_cs)
//   i_addr     word address (W bits)
//   i_dat      write data (W bits)
//   o_dat      read data, valid only while o_ack = 1, else 0
//   o_ack      one-cycle completion pulse
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no request in flight; outputs held at zero
// WAIT  | request captured, counting wait states; i_cs low aborts
// ACK   | access performed on entry; o_ack high for exactly one cycle

module dbus_ram #(
    parameter int             W           = 16,
    parameter int             AW          = 10,
    parameter logic [W-1:0]   BASE        = '0,
    parameter int             WAIT_STATES = 0,
    parameter int             RO_WORDS    = 64
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_cs,
    input  logic         i_we,
    input  logic [W-1:0] i_addr,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat,
    output logic         o_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam bit         WS_ZERO = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef DBUS_RAM_ROPROT_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic          r_we;
    logic [W-1:0]  r_dat;
    logic [W-1:0]  r_mem [0:(1<<AW)-1];

    logic          w_hit;
    logic [AW-1:0] w_idx;
    logic          w_from_idle;
    logic [AW-1:0] w_acc_idx;
    logic          w_acc_we;
    logic [W-1:0]  w_acc_dat;
    logic          w_acc;
    logic          w_ro;
    logic          w_mem_wr;
    logic [W-1:0]  w_rd_dat;

    assign w_hit       = i_cs && (i_addr[W-1:AW] == BASE[W-1:AW]);
    assign w_idx       = i_addr[AW-1:0];
    assign w_from_idle = (r_state == ST_IDLE);

    // With zero wait states the access happens on the accept edge itself,
    // so the live bus values are used; otherwise the captured copies.
    assign w_acc_idx = w_from_idle ? w_idx  : r_idx;
    assign w_acc_we  = w_from_idle ? i_we   : r_we;
    assign w_acc_dat = w_from_idle ? i_dat  : r_dat;

    assign w_acc = (w_from_idle && w_hit && WS_ZERO)
                || ((r_state == ST_WAIT) && i_cs && (r_cnt == 4'd0));

    assign w_ro     = RO_EN && (32'(w_acc_idx) < RO_WORDS);
    assign w_mem_wr = w_acc && w_acc_we && !w_ro;
    assign w_rd_dat = r_mem[w_acc_idx];

    // RAM array is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_wr) begin
            r_mem[w_acc_idx] <= w_acc_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
            o_ack   <= 1'b0;
            o_dat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_ack <= 1'b0;
                    o_dat <= '0;
                    if (w_hit) begin
                        r_idx <= w_idx;
                        r_we  <= i_we;
                        r_dat <= i_dat;
                        if (WS_ZERO) begin
                            o_ack   <= 1'b1;
                            o_dat   <= i_we ? '0 : w_rd_dat;
                            r_state <= ST_ACK;
                        end else begin
                            r_cnt   <= WS_LOAD;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!i_cs) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        o_ack   <= 1'b1;
                        o_dat   <= r_we ? '0 : w_rd_dat;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    o_ack   <= 1'b0;
                    o_dat   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    o_ack   <= 1'b0;
                    o_dat   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_ram.sv
// Directed bench for dbus_ram: one instance with zero wait states and one
// with three, sharing a bus whose request is steered by b_sel.

module tb_dbus_ram;

    logic        clk;
    logic        rst_n;
    logic        b_cs;
    logic        b_sel;
    logic        b_we;
    logic [15:0] b_addr;
    logic [15:0] b_dat;

    logic        cs0, cs3;
    logic [15:0] rdat0, rdat3;
    logic        ack0, ack3;
    logic        w_ack;
    logic [15:0] w_rdat;

    int n_chk  = 0;
    int n_pass = 0;

    assign cs0    = b_cs & ~b_sel;
    assign cs3    = b_cs &  b_sel;
    assign w_ack  = b_sel ? ack3  : ack0;
    assign w_rdat = b_sel ? rdat3 : rdat0;

    dbus_ram #(.W(16), .AW(10), .BASE(16'h0400), .WAIT_STATES(0), .RO_WORDS(64)) u_dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_cs(cs0), .i_we(b_we),
        .i_addr(b_addr), .i_dat(b_dat), .o_dat(rdat0), .o_ack(ack0)
    );

    dbus_ram #(.W(16), .AW(10), .BASE(16'h0400), .WAIT_STATES(3), .RO_WORDS(64)) u_dut3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_cs(cs3), .i_we(b_we),
        .i_addr(b_addr), .i_dat(b_dat), .o_dat(rdat3), .o_ack(ack3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction. lat = number of samples after the accept edge
    // until ack is seen (0 if it never came). Checks ack lasts one cycle.
    task automatic xfer(input bit sel, input bit we, input logic [15:0] addr,
                        input logic [15:0] dat, input bit use_alt,
                        output logic [15:0] rd, output int lat);
        b_sel  = sel;
        b_we   = we;
        b_addr = addr;
        b_dat  = dat;
        b_cs   = 1'b1;
        lat    = 0;
        rd     = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (use_alt && i == 1) begin
                b_addr = addr ^ 16'h0001;
                b_dat  = ~dat;
            end
            if (w_ack) begin
                lat = i;
                rd  = w_rdat;
                break;
            end
        end
        b_cs = 1'b0;
        tick();
        chk("ack_one_cycle", {31'd0, w_ack}, 32'd0);
        chk("dat_after_ack", {16'd0, w_rdat}, 32'd0);
    endtask

    logic [15:0] rd;
    int          lat;
    int          n_ack;
    bit          bad_dat;

    initial begin
        rst_n  = 1'b1;
        b_cs   = 1'b0;
        b_sel  = 1'b0;
        b_we   = 1'b0;
        b_addr = '0;
        b_dat  = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_dat0", {16'd0, rdat0}, 32'd0);
        chk("rst_ack3", {31'd0, ack3}, 32'd0);
        chk("rst_dat3", {16'd0, rdat3}, 32'd0);
        chk("rst_state0", 32'(u_dut0.r_state), 32'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // WS=0 write then read
        xfer(1'b0, 1'b1, 16'h0412, 16'hBEEF, 1'b0, rd, lat);
        chk("ws0_wr_lat", lat, 1);
        chk("ws0_wr_dat", {16'd0, rd}, 32'd0);
        chk("ws0_rd_pre_dat", {16'd0, w_rdat}, 32'd0);
        xfer(1'b0, 1'b0, 16'h0412, 16'h0000, 1'b0, rd, lat);
        chk("ws0_rd_lat", lat, 1);
        chk("ws0_rd_dat", {16'd0, rd}, 32'h0000BEEF);

        // Address miss held for 20 cycles
        b_sel  = 1'b0;
        b_we   = 1'b0;
        b_addr = 16'h0800;
        b_cs   = 1'b1;
        n_ack  = 0;
        bad_dat = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w_ack) n_ack++;
            if (w_rdat !== 16'h0000) bad_dat = 1'b1;
        end
        b_cs = 1'b0;
        chk("miss_ack", n_ack, 0);
        chk("miss_dat", {31'd0, bad_dat}, 32'd0);
        chk("miss_state", 32'(u_dut0.r_state), 32'd0);

        // WS=3: preload, then read with address/data wiggled during WAIT
        xfer(1'b1, 1'b1, 16'h0420, 16'h1234, 1'b0, rd, lat);
        chk("ws3_wr_lat", lat, 4);
        xfer(1'b1, 1'b0, 16'h0420, 16'h0000, 1'b1, rd, lat);
        chk("ws3_rd_lat", lat, 4);
        chk("ws3_rd_dat", {16'd0, rd}, 32'h00001234);

        // WS=3 aborted write leaves old value
        xfer(1'b1, 1'b1, 16'h0430, 16'h7777, 1'b0, rd, lat);
        chk("ws3_old_lat", lat, 4);
        b_sel  = 1'b1;
        b_we   = 1'b1;
        b_addr = 16'h0430;
        b_dat  = 16'h5555;
        b_cs   = 1'b1;
        tick();
        tick();
        b_cs  = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack3) n_ack++;
        end
        chk("abort_no_ack", n_ack, 0);
        xfer(1'b1, 1'b0, 16'h0430, 16'h0000, 1'b0, rd, lat);
        chk("abort_rd_dat", {16'd0, rd}, 32'h00007777);

        // Back-to-back reads with cs held high (WS=0)
        xfer(1'b0, 1'b1, 16'h0401, 16'h1111, 1'b0, rd, lat);
        xfer(1'b0, 1'b1, 16'h0402, 16'h2222, 1'b0, rd, lat);
        b_sel  = 1'b0;
        b_we   = 1'b0;
        b_addr = 16'h0401;
        b_cs   = 1'b1;
        tick();
        chk("b2b_ack1", {31'd0, w_ack}, 32'd1);
        chk("b2b_dat1", {16'd0, w_rdat}, 32'h00001111);
        b_addr = 16'h0402;
        tick();
        chk("b2b_gap_ack", {31'd0, w_ack}, 32'd0);
        chk("b2b_gap_dat", {16'd0, w_rdat}, 32'd0);
        tick();
        chk("b2b_ack2", {31'd0, w_ack}, 32'd1);
        chk("b2b_dat2", {16'd0, w_rdat}, 32'h00002222);
        b_cs = 1'b0;
        tick();
        chk("b2b_end_ack", {31'd0, w_ack}, 32'd0);

        // Write-protect region (offset 10) and first writable word (offset 64)
        xfer(1'b0, 1'b1, 16'h040A, 16'hAAAA, 1'b0, rd, lat);
        chk("ro_wr_lat", lat, 1);
        chk("ro_wr_dat", {16'd0, rd}, 32'd0);
        xfer(1'b0, 1'b0, 16'h040A, 16'h0000, 1'b0, rd, lat);
`ifdef DBUS_RAM_ROPROT_EN
        chk("ro_kept", {31'd0, (rd === 16'hAAAA)}, 32'd0);
`else
        chk("ro_off_stored", {16'd0, rd}, 32'h0000AAAA);
`endif
        xfer(1'b0, 1'b1, 16'h0440, 16'h6464, 1'b0, rd, lat);
        xfer(1'b0, 1'b0, 16'h0440, 16'h0000, 1'b0, rd, lat);
        chk("ro_edge_stored", {16'd0, rd}, 32'h00006464);

        // Reset pulse during WAIT on the WS=3 instance
        b_sel  = 1'b1;
        b_we   = 1'b1;
        b_addr = 16'h0430;
        b_dat  = 16'h9999;
        b_cs   = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        b_cs = 1'b0;
        #1;
        chk("rst_wait_ack", {31'd0, ack3}, 32'd0);
        chk("rst_wait_state", 32'(u_dut3.r_state), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        xfer(1'b1, 1'b0, 16'h0430, 16'h0000, 1'b0, rd, lat);
        chk("rst_wait_target", {16'd0, rd}, 32'h00007777);

        // Reset during ACK drops outputs at once, committed write survives
        b_sel  = 1'b0;
        b_we   = 1'b0;
        b_addr = 16'h0412;
        b_cs   = 1'b1;
        tick();
        chk("rst_ack_pre", {31'd0, ack0}, 32'd1);
        #2 rst_n = 1'b0;
        b_cs = 1'b0;
        #1;
        chk("rst_ack_ack", {31'd0, ack0}, 32'd0);
        chk("rst_ack_dat", {16'd0, rdat0}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        xfer(1'b0, 1'b0, 16'h0412, 16'h0000, 1'b0, rd, lat);
        chk("post_rst_mem", {16'd0, rd}, 32'h0000BEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
